// File: rtl/calc2_pkg.sv
// Shared calc2 types: command and response encodings, capture FSM states and the queued
// request record used by the scheduler and its per-port FIFOs.
package calc2_pkg;

  localparam int NPORT = 4;
  localparam int DW    = 32;

  typedef enum logic [3:0] {
    CMD_IDLE = 4'd0,
    CMD_ADD  = 4'd1,
    CMD_SUB  = 4'd2,
    CMD_SHL  = 4'd5,
    CMD_SHR  = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OPND2 = 1'b1
  } cap_st_e;

  typedef struct packed {
    logic [3:0]    cmd;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [1:0]    tag;
  } req_t;

  function automatic logic cmd_is_valid(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SHL) || (cmd == CMD_SHR);
  endfunction

endpackage

// File: rtl/calc2_req_fifo.sv
// QDEPTH-entry request FIFO, one per requester port. Pointers carry an extra wrap bit so
// full and empty are distinguishable without a separate counter.
module calc2_req_fifo
  import calc2_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  req_t i_wdata,
  input  logic i_pop,
  output req_t o_rdata,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(QDEPTH);

  req_t          r_mem [QDEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + (AW + 1)'(1);
      if (i_pop)  r_rptr <= r_rptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

endmodule

// File: rtl/calc2_req_sched.sv
// calc2 request scheduler: per-port capture/validate, queueing, arbitration onto one ALU and
// result routing. Define CALC2_SCHED_PRIO_EN for fixed lowest-port-first priority.
module calc2_req_sched
  import calc2_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                c_clk,
  input  logic                reset,
  input  logic [4*NPORT-1:0]  req_cmd_in,
  input  logic [DW*NPORT-1:0] req_data_in,
  input  logic [2*NPORT-1:0]  req_tag_in,
  output logic [2*NPORT-1:0]  out_resp,
  output logic [DW*NPORT-1:0] out_data,
  output logic [2*NPORT-1:0]  out_tag,
  output logic                alu_vld,
  input  logic                alu_rdy,
  output logic [3:0]          alu_cmd,
  output logic [DW-1:0]       alu_op1,
  output logic [DW-1:0]       alu_op2,
  output logic [1:0]          alu_port,
  output logic [1:0]          alu_tag,
  input  logic                alu_resp_vld,
  input  logic [1:0]          alu_resp,
  input  logic [DW-1:0]       alu_data,
  input  logic [1:0]          alu_resp_port,
  input  logic [1:0]          alu_resp_tag
);

  cap_st_e         r_st       [NPORT];
  logic [3:0]      r_cap_cmd  [NPORT];
  logic [DW-1:0]   r_cap_op1  [NPORT];
  logic [1:0]      r_cap_tag  [NPORT];
  logic [3:0]      r_outst    [NPORT];
  logic [1:0]      r_pend_tag [NPORT];
  logic [1:0]      r_out_resp [NPORT];
  logic [DW-1:0]   r_out_data [NPORT];
  logic [1:0]      r_out_tag  [NPORT];
  logic [NPORT-1:0] r_pend_vld;

  logic            r_alu_vld;
  logic [3:0]      r_alu_cmd;
  logic [DW-1:0]   r_alu_op1;
  logic [DW-1:0]   r_alu_op2;
  logic [1:0]      r_alu_port;
  logic [1:0]      r_alu_tag;

  req_t            w_req    [NPORT];
  req_t            w_head   [NPORT];
  req_t            w_fifo_q [NPORT];
  logic [NPORT-1:0] w_full, w_empty, w_push, w_pop, w_rej, w_acc, w_alu_hit, w_cand;
  logic            w_load;
  logic            w_gnt_vld;
  logic [1:0]      w_gnt;
  logic [1:0]      w_idx;
  logic [1:0]      w_base;

`ifdef CALC2_SCHED_PRIO_EN
  assign w_base = '0;
`else
  logic [1:0]      r_rr;
  assign w_base = r_rr;
`endif

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    calc2_req_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .i_clk   (c_clk),
      .i_rst_n (reset),
      .i_push  (w_push[p]),
      .i_wdata (w_req[p]),
      .i_pop   (w_pop[p]),
      .o_rdata (w_fifo_q[p]),
      .o_full  (w_full[p]),
      .o_empty (w_empty[p])
    );
    assign out_resp[2*p +: 2]  = r_out_resp[p];
    assign out_data[DW*p +: DW] = r_out_data[p];
    assign out_tag[2*p +: 2]   = r_out_tag[p];
  end

  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      w_req[p] = '{cmd: r_cap_cmd[p], op1: r_cap_op1[p], op2: req_data_in[DW*p +: DW],
                   tag: r_cap_tag[p]};
      w_rej[p] = (r_st[p] == ST_OPND2) &&
                 (!cmd_is_valid(r_cap_cmd[p]) || r_outst[p][r_cap_tag[p]] || w_full[p]);
      w_acc[p] = (r_st[p] == ST_OPND2) && !w_rej[p];
      w_alu_hit[p] = alu_resp_vld && (alu_resp_port == 2'(p)) && r_outst[p][alu_resp_tag];
      // A request accepted this cycle is a candidate at once; an empty queue is bypassed.
      w_cand[p] = !w_empty[p] || w_acc[p];
      w_head[p] = w_empty[p] ? w_req[p] : w_fifo_q[p];
    end
  end

  assign w_load = !r_alu_vld || alu_rdy;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = '0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      w_idx = w_base + 2'(i);
      if (w_cand[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_idx;
      end
    end
    for (int p = 0; p < NPORT; p++) begin
      w_pop[p]  = w_load && w_gnt_vld && (w_gnt == 2'(p)) && !w_empty[p];
      w_push[p] = w_acc[p] && !(w_load && w_gnt_vld && (w_gnt == 2'(p)) && w_empty[p]);
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NPORT; p++) begin
        r_st[p]       <= ST_IDLE;
        r_cap_cmd[p]  <= '0;
        r_cap_op1[p]  <= '0;
        r_cap_tag[p]  <= '0;
        r_outst[p]    <= '0;
        r_pend_tag[p] <= '0;
        r_out_resp[p] <= RESP_NONE;
        r_out_data[p] <= '0;
        r_out_tag[p]  <= '0;
      end
      r_pend_vld <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        case (r_st[p])
          ST_IDLE: begin
            if (req_cmd_in[4*p +: 4] != 4'd0) begin
              r_st[p]      <= ST_OPND2;
              r_cap_cmd[p] <= req_cmd_in[4*p +: 4];
              r_cap_op1[p] <= req_data_in[DW*p +: DW];
              r_cap_tag[p] <= req_tag_in[2*p +: 2];
            end
          end
          default: r_st[p] <= ST_IDLE;
        endcase

        if (w_acc[p])     r_outst[p][r_cap_tag[p]] <= 1'b1;
        if (w_alu_hit[p]) r_outst[p][alu_resp_tag] <= 1'b0;

        r_out_resp[p] <= RESP_NONE;
        r_out_data[p] <= '0;
        r_out_tag[p]  <= '0;
        // ALU result beats rejects; a colliding reject waits in the one-entry pending slot.
        if (w_alu_hit[p]) begin
          r_out_resp[p] <= alu_resp;
          r_out_data[p] <= alu_data;
          r_out_tag[p]  <= alu_resp_tag;
          if (w_rej[p] && !r_pend_vld[p]) begin
            r_pend_vld[p] <= 1'b1;
            r_pend_tag[p] <= r_cap_tag[p];
          end
        end else if (r_pend_vld[p]) begin
          r_out_resp[p] <= RESP_ERR;
          r_out_tag[p]  <= r_pend_tag[p];
          r_pend_vld[p] <= w_rej[p];
          if (w_rej[p]) r_pend_tag[p] <= r_cap_tag[p];
        end else if (w_rej[p]) begin
          r_out_resp[p] <= RESP_ERR;
          r_out_tag[p]  <= r_cap_tag[p];
        end
      end
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      r_alu_vld  <= 1'b0;
      r_alu_cmd  <= '0;
      r_alu_op1  <= '0;
      r_alu_op2  <= '0;
      r_alu_port <= '0;
      r_alu_tag  <= '0;
`ifndef CALC2_SCHED_PRIO_EN
      r_rr       <= '0;
`endif
    end else if (w_load) begin
      r_alu_vld <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_alu_cmd  <= w_head[w_gnt].cmd;
        r_alu_op1  <= w_head[w_gnt].op1;
        r_alu_op2  <= w_head[w_gnt].op2;
        r_alu_tag  <= w_head[w_gnt].tag;
        r_alu_port <= w_gnt;
`ifndef CALC2_SCHED_PRIO_EN
        r_rr       <= w_gnt + 2'd1;
`endif
      end
    end
  end

  assign alu_vld  = r_alu_vld;
  assign alu_cmd  = r_alu_cmd;
  assign alu_op1  = r_alu_op1;
  assign alu_op2  = r_alu_op2;
  assign alu_port = r_alu_port;
  assign alu_tag  = r_alu_tag;

endmodule

// File: tb/tb_calc2_req_sched.sv
// Scoreboard bench for calc2_req_sched: directed requests push expected issues/responses,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_calc2_req_sched;
  import calc2_pkg::*;

  logic         c_clk = 1'b0;
  logic         reset = 1'b1;
  logic [15:0]  req_cmd_in;
  logic [127:0] req_data_in;
  logic [7:0]   req_tag_in;
  logic [7:0]   out_resp;
  logic [127:0] out_data;
  logic [7:0]   out_tag;
  logic         alu_vld, alu_rdy;
  logic [3:0]   alu_cmd;
  logic [31:0]  alu_op1, alu_op2;
  logic [1:0]   alu_port, alu_tag;
  logic         alu_resp_vld;
  logic [1:0]   alu_resp;
  logic [31:0]  alu_data;
  logic [1:0]   alu_resp_port, alu_resp_tag;

  always #5 c_clk = ~c_clk;

  calc2_req_sched #(.QDEPTH(2)) dut (
    .c_clk         (c_clk),
    .reset         (reset),
    .req_cmd_in    (req_cmd_in),
    .req_data_in   (req_data_in),
    .req_tag_in    (req_tag_in),
    .out_resp      (out_resp),
    .out_data      (out_data),
    .out_tag       (out_tag),
    .alu_vld       (alu_vld),
    .alu_rdy       (alu_rdy),
    .alu_cmd       (alu_cmd),
    .alu_op1       (alu_op1),
    .alu_op2       (alu_op2),
    .alu_port      (alu_port),
    .alu_tag       (alu_tag),
    .alu_resp_vld  (alu_resp_vld),
    .alu_resp      (alu_resp),
    .alu_data      (alu_data),
    .alu_resp_port (alu_resp_port),
    .alu_resp_tag  (alu_resp_tag)
  );

  typedef struct {
    logic [1:0]  port;
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
  } rsp_t;

  typedef struct {
    logic [1:0]  port;
    logic [1:0]  tag;
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
  } iss_t;

  rsp_t exp_rsp[$];
  iss_t exp_iss[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   m_idx;
  rsp_t m_r;
  iss_t m_s;
  int   ord[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic drv(input int p, input int c, input int d, input int t);
    req_cmd_in[4*p +: 4]   = 4'(c);
    req_data_in[32*p +: 32] = 32'(d);
    req_tag_in[2*p +: 2]   = 2'(t);
  endtask

  // Command cycle then operand2 cycle; returns in the cycle after OPND2.
  task automatic req1(input int p, input int c, input int o1, input int o2, input int t);
    drv(p, c, o1, t);
    tick();
    drv(p, 0, o2, 0);
    tick();
    drv(p, 0, 0, 0);
  endtask

  task automatic exp_r(input int p, input int r, input int d, input int t);
    exp_rsp.push_back('{port: 2'(p), resp: 2'(r), data: 32'(d), tag: 2'(t)});
  endtask

  task automatic exp_i(input int p, input int t, input int c, input int o1, input int o2);
    exp_iss.push_back('{port: 2'(p), tag: 2'(t), cmd: 4'(c), op1: 32'(o1), op2: 32'(o2)});
  endtask

  task automatic alu_ret(input int p, input int t, input int r, input int d, input bit expect_out);
    alu_resp_vld  = 1'b1;
    alu_resp_port = 2'(p);
    alu_resp_tag  = 2'(t);
    alu_resp      = 2'(r);
    alu_data      = 32'(d);
    if (expect_out) exp_r(p, r, d, t);
    tick();
    alu_resp_vld = 1'b0;
    alu_resp     = '0;
    alu_data     = '0;
  endtask

  always @(negedge c_clk) begin
    if (reset) begin
      for (int p = 0; p < 4; p++) begin
        if (out_resp[2*p +: 2] != 2'd0) begin
          m_idx = -1;
          for (int i = 0; i < exp_rsp.size(); i++)
            if (m_idx < 0 && exp_rsp[i].port == 2'(p)) m_idx = i;
          if (m_idx < 0) begin
            chk($sformatf("unexpected_resp_p%0d", p), 32'(out_resp[2*p +: 2]), 32'd0);
          end else begin
            m_r = exp_rsp[m_idx];
            exp_rsp.delete(m_idx);
            chk($sformatf("resp_p%0d", p), 32'(out_resp[2*p +: 2]), 32'(m_r.resp));
            chk($sformatf("data_p%0d", p), out_data[32*p +: 32], m_r.data);
            chk($sformatf("tag_p%0d", p), 32'(out_tag[2*p +: 2]), 32'(m_r.tag));
          end
        end
      end
      if (alu_vld) begin
        if (exp_iss.size() == 0) begin
          chk("unexpected_issue", 32'(alu_vld), 32'd0);
        end else begin
          m_s = exp_iss[0];
          chk("iss_port", 32'(alu_port), 32'(m_s.port));
          chk("iss_tag", 32'(alu_tag), 32'(m_s.tag));
          chk("iss_cmd", 32'(alu_cmd), 32'(m_s.cmd));
          chk("iss_op1", alu_op1, m_s.op1);
          chk("iss_op2", alu_op2, m_s.op2);
          if (alu_rdy) exp_iss.delete(0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    req_cmd_in = '0; req_data_in = '0; req_tag_in = '0;
    alu_rdy = 1'b1; alu_resp_vld = 1'b0; alu_resp = '0; alu_data = '0;
    alu_resp_port = '0; alu_resp_tag = '0;
    #1 reset = 1'b0;
    #2;
    chk("rst_out_resp", 32'(out_resp), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_data", 32'(|out_data), 32'd0);
    chk("rst_alu_vld", 32'(alu_vld), 32'd0);
    chk("rst_alu_fields", 32'({alu_cmd, alu_port, alu_tag}), 32'd0);
    chk("rst_alu_ops", 32'(|{alu_op1, alu_op2}), 32'd0);
    #9 reset = 1'b1;
    tick();

    // All four ports at once, pointer 0: grants 0,1,2,3.
    for (int p = 0; p < 4; p++) begin
      drv(p, 1, 32'h100 + p, p);
      exp_i(p, p, 1, 32'h100 + p, 32'h10 + p);
    end
    tick();
    for (int p = 0; p < 4; p++) drv(p, 0, 32'h10 + p, 0);
    tick();
    for (int p = 0; p < 4; p++) drv(p, 0, 0, 0);
    repeat (5) tick();
    for (int p = 0; p < 4; p++) alu_ret(p, p, 1, 32'hA0 + p, 1'b1);
    repeat (2) tick();

    // Single add on port0: issue the cycle after OPND2, result the cycle after alu_resp_vld.
    exp_i(0, 1, 1, 32'h30, 32'h20);
    req1(0, 1, 32'h30, 32'h20, 1);
    @(negedge c_clk);
    chk("t1_issue_latency", 32'(alu_vld), 32'd1);
    tick();
    tick();
    alu_ret(0, 1, 1, 32'h50, 1'b1);
    @(negedge c_clk);
    chk("t1_out_resp", 32'(out_resp[1:0]), 32'd1);
    chk("t1_out_data", out_data[31:0], 32'h50);
    tick();
    @(negedge c_clk);
    chk("t1_resp_clears", 32'(out_resp[1:0]), 32'd0);
    tick();

    // Invalid command on port2.
    exp_r(2, 2, 0, 2);
    req1(2, 3, 32'h11, 32'h22, 2);
    @(negedge c_clk);
    chk("t2_reject_timing", 32'(out_resp[5:4]), 32'd2);
    chk("t2_no_issue", 32'(alu_vld), 32'd0);
    tick();
    @(negedge c_clk);
    chk("t2_no_issue_later", 32'(alu_vld), 32'd0);
    tick();

    // Move the pointer to 2 with a port1 request, then all four again.
    exp_i(1, 3, 2, 32'h9, 32'h4);
    req1(1, 2, 32'h9, 32'h4, 3);
    tick();
    alu_ret(1, 3, 1, 32'h5, 1'b1);
    tick();
`ifdef CALC2_SCHED_PRIO_EN
    ord = '{0, 1, 2, 3};
`else
    ord = '{2, 3, 0, 1};
`endif
    for (int i = 0; i < 4; i++) exp_i(ord[i], 0, 2, 32'h200 + ord[i], 32'h1);
    for (int p = 0; p < 4; p++) drv(p, 2, 32'h200 + p, 0);
    tick();
    for (int p = 0; p < 4; p++) drv(p, 0, 32'h1, 0);
    tick();
    for (int p = 0; p < 4; p++) drv(p, 0, 0, 0);
    repeat (5) tick();
    for (int p = 0; p < 4; p++) alu_ret(p, 0, 1, 32'h300 + p, 1'b1);
    repeat (2) tick();

    // Stalled ALU: issue register busy, port1 queue fills, third tag and reused tag rejected.
    alu_rdy = 1'b0;
    exp_i(0, 2, 1, 32'h40, 32'h41);
    req1(0, 1, 32'h40, 32'h41, 2);
    exp_i(1, 0, 1, 32'h50, 32'h51);
    req1(1, 1, 32'h50, 32'h51, 0);
    exp_i(1, 1, 1, 32'h60, 32'h61);
    req1(1, 1, 32'h60, 32'h61, 1);
    exp_r(1, 2, 0, 2);
    req1(1, 1, 32'h70, 32'h71, 2);
    @(negedge c_clk);
    chk("t5_full_reject", 32'(out_resp[3:2]), 32'd2);
    chk("t5_full_reject_tag", 32'(out_tag[3:2]), 32'd2);
    exp_r(1, 2, 0, 0);
    req1(1, 1, 32'h80, 32'h81, 0);
    tick();
    alu_rdy = 1'b1;
    repeat (4) tick();
    alu_ret(0, 2, 1, 32'h81, 1'b1);
    alu_ret(1, 0, 1, 32'hA1, 1'b1);
    alu_ret(1, 1, 2, 32'h0, 1'b1);
    tick();

    // ALU result and reject collide on port3.
    exp_i(3, 0, 1, 32'h5, 32'h6);
    req1(3, 1, 32'h5, 32'h6, 0);
    tick();
    drv(3, 4, 32'h1, 1);
    tick();
    drv(3, 0, 32'h2, 0);
    alu_resp_vld = 1'b1; alu_resp_port = 2'd3; alu_resp_tag = 2'd0;
    alu_resp = 2'd1; alu_data = 32'h77;
    exp_r(3, 1, 32'h77, 0);
    exp_r(3, 2, 0, 1);
    tick();
    drv(3, 0, 0, 0);
    alu_resp_vld = 1'b0; alu_resp = '0; alu_data = '0;
    @(negedge c_clk);
    chk("t6_alu_first", 32'(out_resp[7:6]), 32'd1);
    chk("t6_alu_data", out_data[127:96], 32'h77);
    tick();
    @(negedge c_clk);
    chk("t6_reject_second", 32'(out_resp[7:6]), 32'd2);
    chk("t6_reject_tag", 32'(out_tag[7:6]), 32'd1);
    tick();

    // Reset while port0 is in OPND2 with one request queued behind a stalled issue.
    alu_rdy = 1'b0;
    exp_i(1, 0, 1, 32'hA, 32'hB);
    req1(1, 1, 32'hA, 32'hB, 0);
    req1(0, 1, 32'hC, 32'hD, 3);
    drv(0, 1, 32'hE, 1);
    tick();
    drv(0, 0, 32'hF, 0);
    #2 reset = 1'b0;
    exp_iss.delete();
    #1;
    chk("t7_rst_out_resp", 32'(out_resp), 32'd0);
    chk("t7_rst_alu_vld", 32'(alu_vld), 32'd0);
    chk("t7_rst_alu_fields", 32'({alu_cmd, alu_port, alu_tag}), 32'd0);
    chk("t7_rst_out_data", 32'(|out_data), 32'd0);
    drv(0, 0, 0, 0);
    @(negedge c_clk);
    reset = 1'b1;
    alu_rdy = 1'b1;
    tick();
    alu_ret(0, 3, 1, 32'h99, 1'b0);
    @(negedge c_clk);
    chk("t7_stale_dropped", 32'(out_resp), 32'd0);
    tick();
    alu_ret(1, 0, 1, 32'h98, 1'b0);
    @(negedge c_clk);
    chk("t7_stale_dropped2", 32'(out_resp), 32'd0);
    chk("t7_queue_flushed", 32'(alu_vld), 32'd0);
    tick();
    exp_i(0, 3, 1, 32'h1, 32'h2);
    req1(0, 1, 32'h1, 32'h2, 3);
    @(negedge c_clk);
    chk("t7_post_reset_issue", 32'(alu_vld), 32'd1);
    tick();
    tick();
    alu_ret(0, 3, 1, 32'h3, 1'b1);
    repeat (3) tick();

    chk("exp_rsp_drained", 32'(exp_rsp.size()), 32'd0);
    chk("exp_iss_drained", 32'(exp_iss.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
